wb_led_chaser: RTL and testbench

//   Wishbone master that feeds wb_leds: periodically writes an LED chase pattern, reads it back
//   and checks it. Sits directly upstream of wb_leds, in place of a CPU, on board bring-up images.

---
 rtl/wb_led_chaser_pkg.sv | 21 ++
 rtl/wb_led_chaser_tick_gen.sv | 30 +++
 rtl/wb_led_chaser.sv | 150 +++++++++++++++
 tb/tb_wb_led_chaser.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_led_chaser_pkg.sv
// Shared types and helpers for the LED chaser Wishbone master.
// FSM state encoding, chase direction constants and counter sizing.
package wb_led_chaser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_GAP   = 3'd2,
      ST_READ  = 3'd3,
      ST_CHECK = 3'd4
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_bits(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wb_led_chaser_tick_gen.sv
// Prescaler: single-cycle o_tick every PERIOD clocks while i_en is high, counter parked at 0 otherwise.
// Latency: tick is combinational from the count; no backpressure, ticks are never held.
module wb_led_chaser_tick_gen
   import wb_led_chaser_pkg::*;
#(
   parameter int PERIOD = 1000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_tick
);

   localparam int              CW   = cnt_bits(PERIOD - 1);
   localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

   logic [CW-1:0] r_cnt;
   logic          w_at_last;

   assign w_at_last = (r_cnt == LAST);
   assign o_tick    = i_en && w_at_last;

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en || w_at_last)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/wb_led_chaser.sv
// Wishbone master: on each tick writes the chase pattern, reads it back and compares; sticky mismatch/timeout flags.
// Latency: tick to stb 1 clock; WRITE/READ stall until ack or TIMEOUT clocks, ticks arriving while busy are dropped.
module wb_led_chaser
   import wb_led_chaser_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int ENABLES = WIDTH / 8,
   parameter int PERIOD  = 1000,
   parameter int TIMEOUT = 15,
   parameter int BOUNCE  = 0
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               enable_i,
   output logic               wb_cyc_o,
   output logic               wb_stb_o,
   output logic               wb_we_o,
   output logic [ENABLES-1:0] wb_sel_o,
   output logic [WIDTH-1:0]   wb_dat_o,
   input  logic               wb_ack_i,
   input  logic [WIDTH-1:0]   wb_dat_i,
   output logic [WIDTH-1:0]   pattern_o,
   output logic               mismatch_o,
   output logic               timeout_o,
   output logic               busy_o
);

   localparam logic [ENABLES-1:0] SEL_ALL = {ENABLES{1'b1}};
   localparam int                 TW      = cnt_bits(TIMEOUT);
   localparam logic [TW-1:0]      TO_LAST = TW'(TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next;
   logic             w_tick;
   logic             w_stb;
   logic             w_expire;
   logic [TW-1:0]    r_to_cnt;
   logic [WIDTH-1:0] r_pattern;
   logic [WIDTH-1:0] r_rdata;
   logic [WIDTH-1:0] w_pat_next;
   logic             r_dir;
   logic             w_dir_next;
   logic             w_go_right;
   logic             r_mismatch;
   logic             r_timeout;

   wb_led_chaser_tick_gen #(.PERIOD(PERIOD)) u_tick (
      .i_clk  (wb_clk_i),
      .i_rst  (wb_rst_i),
      .i_en   (enable_i),
      .o_tick (w_tick)
   );

   assign w_stb    = (r_state == ST_WRITE) || (r_state == ST_READ);
   // An ack in the final allowed clock still completes the access.
   assign w_expire = w_stb && !wb_ack_i && (r_to_cnt == TO_LAST);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_tick) w_next = ST_WRITE;
         ST_WRITE: if (wb_ack_i) w_next = ST_GAP;
                   else if (w_expire) w_next = ST_IDLE;
         ST_GAP:   w_next = ST_READ;
         ST_READ:  if (wb_ack_i) w_next = ST_CHECK;
                   else if (w_expire) w_next = ST_IDLE;
         ST_CHECK: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
      wb_we_o  = 1'b0;
      wb_sel_o = '0;
      wb_dat_o = '0;
      case (r_state)
         ST_WRITE: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = 1'b1;
            wb_sel_o = SEL_ALL;
            wb_dat_o = r_pattern;
         end
         ST_READ: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_sel_o = SEL_ALL;
         end
         default: ;
      endcase
   end

   // Per-access wait counter; idle/gap states between accesses clear it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !w_stb)
         r_to_cnt <= '0;
      else if (!wb_ack_i)
         r_to_cnt <= r_to_cnt + 1'b1;
   end

   always_comb begin
      w_go_right = (r_dir == DIR_RIGHT) ? !r_pattern[0] : r_pattern[WIDTH-1];
      w_pat_next = r_pattern;
      w_dir_next = r_dir;
      if (WIDTH > 1) begin
         if (BOUNCE != 0) begin
            w_pat_next = w_go_right ? (r_pattern >> 1) : (r_pattern << 1);
            w_dir_next = w_go_right ? DIR_RIGHT : DIR_LEFT;
         end else begin
            w_pat_next = (r_pattern << 1) | (r_pattern >> (WIDTH - 1));
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_pattern  <= WIDTH'(1);
         r_dir      <= DIR_LEFT;
         r_rdata    <= '0;
         r_mismatch <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (r_state == ST_READ && wb_ack_i)
            r_rdata <= wb_dat_i;
         if (r_state == ST_CHECK) begin
            if (r_rdata != r_pattern)
               r_mismatch <= 1'b1;
            r_pattern <= w_pat_next;
            r_dir     <= w_dir_next;
         end
         if (w_expire)
            r_timeout <= 1'b1;
      end
   end

   assign pattern_o  = r_pattern;
   assign mismatch_o = r_mismatch;
   assign timeout_o  = r_timeout;
   assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_led_chaser.sv
// Bench for wb_led_chaser: a per-access timeline planner predicts every output cycle from the
// slave plan chosen at each tick; a second instance exercises the bounce sequence.
module tb_wb_led_chaser;

   localparam int W     = 8;
   localparam int P     = 8;
   localparam int TO    = 15;
   localparam int NEVER = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, en, cyc, stb, we, ack, mis, tmo, busy;
   logic [0:0]   sel;
   logic [W-1:0] dat_o, dat_i, pat;

   wb_led_chaser #(.WIDTH(W), .ENABLES(1), .PERIOD(P), .TIMEOUT(TO), .BOUNCE(0)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(en),
      .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel), .wb_dat_o(dat_o),
      .wb_ack_i(ack), .wb_dat_i(dat_i),
      .pattern_o(pat), .mismatch_o(mis), .timeout_o(tmo), .busy_o(busy)
   );

   logic       b_rst, b_en, b_cyc, b_stb, b_we, b_ack, b_mis, b_tmo, b_busy;
   logic [0:0] b_sel;
   logic [3:0] b_dat_o, b_dat_i, b_pat;

   wb_led_chaser #(.WIDTH(4), .ENABLES(1), .PERIOD(P), .TIMEOUT(TO), .BOUNCE(1)) dut_b (
      .wb_clk_i(clk), .wb_rst_i(b_rst), .enable_i(b_en),
      .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_we), .wb_sel_o(b_sel), .wb_dat_o(b_dat_o),
      .wb_ack_i(b_ack), .wb_dat_i(b_dat_i),
      .pattern_o(b_pat), .mismatch_o(b_mis), .timeout_o(b_tmo), .busy_o(b_busy)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for one cycle: {cyc,stb,we,sel,dat}, busy, pattern, mismatch, timeout.
   typedef struct packed {
      logic [11:0] bus;
      logic        busy;
      logic [7:0]  pat;
      logic        mis;
      logic        tmo;
   } exp_t;

   exp_t       q[$];
   exp_t       c_e;
   int         m_adv, m_pre, m_acc;
   logic       m_mis, m_tmo, m_tick;
   logic       m_valid = 1'b0;
   logic       m_cur_idle = 1'b1;
   int         k_wlo, k_whi, k_rlo, k_rhi, k_mask_at, k_pct;
   int         p_wwait = 0;
   int         p_rwait = 0;
   logic [7:0] p_mask = 8'h00;

   function automatic logic [7:0] rot_pat(input int adv);
      logic [7:0] one;
      one = 8'd1;
      return one << (adv % W);
   endfunction

   function automatic logic [3:0] bounce_pat(input int i);
      logic [3:0] one;
      int k;
      one = 4'd1;
      k = i % 6;
      return one << ((k < 4) ? k : 6 - k);
   endfunction

   task automatic push_n(input int n, input logic [11:0] bus);
      for (int i = 0; i < n; i++)
         q.push_back({bus, 1'b1, rot_pat(m_adv), m_mis, m_tmo});
   endtask

   // Plan the whole access at tick time: the slave follows p_* so every cycle is known now.
   task automatic build();
      logic [7:0] cur;
      cur = rot_pat(m_adv);
      m_acc++;
      p_wwait = int'($urandom_range(k_whi, k_wlo));
      p_rwait = int'($urandom_range(k_rhi, k_rlo));
      p_mask  = 8'h00;
      if (m_acc == k_mask_at) p_mask = 8'h10;
      else if (int'($urandom_range(99, 0)) < k_pct) p_mask = 8'($urandom_range(255, 1));
      push_n((p_wwait < TO) ? p_wwait + 1 : TO, {3'b111, 1'b1, cur});
      if (p_wwait >= TO) begin m_tmo = 1'b1; return; end
      push_n(1, 12'h000);
      push_n((p_rwait < TO) ? p_rwait + 1 : TO, {3'b110, 1'b1, 8'h00});
      if (p_rwait >= TO) begin m_tmo = 1'b1; return; end
      push_n(1, 12'h000);
      if (p_mask != 8'h00) m_mis = 1'b1;
      m_adv++;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            q.delete();
            m_adv = 0; m_pre = 0; m_acc = 0;
            m_mis = 1'b0; m_tmo = 1'b0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            m_tick = 1'b0;
            if (!en) m_pre = 0;
            else if (m_pre == P - 1) begin m_tick = 1'b1; m_pre = 0; end
            else m_pre++;
            if (m_tick && m_cur_idle) build();
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            if (q.size() == 0) begin
               m_cur_idle = 1'b1;
               c_e = {12'h000, 1'b0, rot_pat(m_adv), m_mis, m_tmo};
            end else begin
               m_cur_idle = 1'b0;
               c_e = q.pop_front();
            end
            check("cycle", 32'({cyc, stb, we, sel, dat_o, busy, pat, mis, tmo}), 32'(c_e));
         end
      end
   end

   // Slave: ack after p_*wait stalled clocks; readback corrupted by p_mask.
   logic [7:0] mem = 8'h00;
   int         s_cnt = 0;
   initial begin
      ack = 1'b0; dat_i = '0;
      forever begin
         @(negedge clk);
         if (stb) begin
            ack   = (s_cnt == (we ? p_wwait : p_rwait));
            dat_i = mem ^ p_mask;
            if (ack && we) mem = dat_o;
            s_cnt++;
         end else begin
            ack = 1'b0; dat_i = '0; s_cnt = 0;
         end
      end
   end

   logic [3:0] b_mem = 4'h0;
   initial begin
      b_ack = 1'b0; b_dat_i = '0;
      forever begin
         @(negedge clk);
         b_ack   = b_stb;
         b_dat_i = b_mem;
         if (b_stb && b_we) b_mem = b_dat_o;
      end
   end

   logic [7:0] wr_log[$];
   int         runs[$];
   int         run_len = 0;
   logic       prev_stb = 1'b0;
   logic [3:0] b_log[$];
   logic       b_prev = 1'b0;
   int         b_bad_ctl = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            wr_log.delete(); runs.delete(); run_len = 0; prev_stb = 1'b0;
         end else begin
            if (stb && we && !prev_stb) wr_log.push_back(dat_o);
            if (stb) run_len++;
            else if (prev_stb) begin runs.push_back(run_len); run_len = 0; end
            prev_stb = stb;
         end
         if (b_stb && b_we && !b_prev) b_log.push_back(b_dat_o);
         if (b_stb && ({b_cyc, b_sel, b_busy} != 3'b111)) b_bad_ctl++;
         b_prev = b_stb;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_waits(input int wlo, input int whi, input int rlo, input int rhi);
      k_wlo = wlo; k_whi = whi; k_rlo = rlo; k_rhi = rhi;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int c;
      c = 0;
      while (wr_log.size() < n && c < budget) begin @(negedge clk); c++; end
      if (wr_log.size() < n) check("wait_writes", 32'(wr_log.size()), 32'(n));
   endtask

   logic [7:0] chase[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [3:0] b_lit[8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

   initial begin
      int c;
      rst = 1'b1; en = 1'b0; b_rst = 1'b1; b_en = 1'b0;
      set_waits(0, 1, 0, 1); k_mask_at = 0; k_pct = 0;
      repeat (3) @(negedge clk);
      check("reset_pattern", 32'(pat), 32'h01);
      check("reset_outputs", 32'({cyc, stb, we, sel, dat_o, busy, mis, tmo}), 32'h0);

      // Plain chase with a quick slave.
      rst = 1'b0; en = 1'b1; b_rst = 1'b0; b_en = 1'b1;
      wait_writes(9, 400);
      for (int i = 0; i < 9; i++)
         if (i < wr_log.size()) check("chase_write", 32'(wr_log[i]), 32'(chase[i]));
      check("chase_flags", 32'({mis, tmo}), 32'h0);

      // Slave never acks: stb for exactly TIMEOUT clocks, pattern held.
      do_reset();
      set_waits(NEVER, NEVER, 0, 0);
      en = 1'b1;
      c = 0;
      while (!tmo && c < 100) begin @(negedge clk); c++; end
      @(negedge clk);
      en = 1'b0;
      check("timeout_flag", 32'(tmo), 32'h1);
      check("timeout_stb_len", (runs.size() > 0) ? 32'(runs[0]) : 32'hffff_ffff, 32'd15);
      check("timeout_pattern", 32'(pat), 32'h01);

      // Ack in the last allowed clock completes normally.
      do_reset();
      set_waits(TO - 1, TO - 1, TO - 1, TO - 1);
      en = 1'b1;
      wait_writes(2, 200);
      check("edge_ack_no_timeout", 32'(tmo), 32'h0);
      check("edge_ack_stb_len", (runs.size() > 0) ? 32'(runs[0]) : 32'hffff_ffff, 32'd15);
      if (wr_log.size() > 1) check("edge_ack_advance", 32'(wr_log[1]), 32'h02);

      // Corrupted readback on the 5th update.
      do_reset();
      set_waits(0, 1, 0, 1); k_mask_at = 5;
      en = 1'b1;
      wait_writes(5, 400);
      check("mismatch_before", 32'(mis), 32'h0);
      wait_writes(6, 100);
      check("mismatch_after", 32'(mis), 32'h1);
      if (wr_log.size() > 5) check("pattern_after_corrupt", 32'(wr_log[5]), 32'h20);
      k_mask_at = 0;

      // Reset while stb is high in READ.
      set_waits(0, 1, 2, 3);
      c = 0;
      while (!(stb && !we) && c < 100) begin @(negedge clk); c++; end
      check("read_seen", 32'(stb && !we), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_read_bus", 32'({cyc, stb}), 32'h0);
      check("rst_mid_read_state", 32'({pat, mis, tmo}), 32'h004);
      @(negedge clk);
      rst = 1'b0; en = 1'b0;

      // Wait-stated slave, enable dropped during WRITE.
      do_reset();
      set_waits(3, 3, 3, 3);
      en = 1'b1;
      c = 0;
      while (!(stb && we) && c < 50) begin @(negedge clk); c++; end
      en = 1'b0;
      repeat (30) @(negedge clk);
      check("drop_en_runs", 32'(runs.size()), 32'd2);
      if (runs.size() > 1) begin
         check("drop_en_write_len", 32'(runs[0]), 32'd4);
         check("drop_en_read_len", 32'(runs[1]), 32'd4);
      end
      check("drop_en_pattern", 32'({pat, busy}), 32'h004);

      // Randomized run: enable toggling, varied slave timing, corrupt reads, occasional reset.
      do_reset();
      k_pct = 15;
      en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (i % 400 == 0) begin
            case ($urandom_range(4, 0))
               0: set_waits(0, 2, 0, 2);
               1: set_waits(0, 6, 0, 6);
               2: set_waits(13, 16, 13, 16);
               3: set_waits(0, 3, NEVER, NEVER);
               default: set_waits(NEVER, NEVER, 0, 1);
            endcase
         end
         if ($urandom_range(99, 0) < 2) en = ~en;
         rst = ($urandom_range(999, 0) < 3);
      end
      rst = 1'b0;

      check("bounce_log_len", 32'(b_log.size() >= 16), 32'h1);
      for (int i = 0; i < 8; i++)
         if (i < b_log.size()) check("bounce_literal", 32'(b_log[i]), 32'(b_lit[i]));
      for (int i = 0; i < 16; i++)
         if (i < b_log.size()) check("bounce_seq", 32'(b_log[i]), 32'(bounce_pat(i)));
      check("bounce_ctl", 32'(b_bad_ctl), 32'd0);
      check("bounce_flags", 32'({b_mis, b_tmo}), 32'h0);
      check("bounce_pattern_onehot", 32'($countones(b_pat)), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
